// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB register block in front of the 8-bit timer counter core.
// Holds TDR (reload/compare data), TCR (control fields) and TSR (sticky
// overflow/underflow flags), and drives the control fields to the counter.
// Build option: define TIMER_APB_WAIT_EN to insert one wait state per transfer.
module timer_apb_regs #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              ovf_set,
    input  logic              udf_set,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              updown_o,
    output logic              en_o,
    output logic [1:0]        cks_o
);

    localparam logic [ADDR_W-1:0] ADDR_TDR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_TCR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TSR = ADDR_W'(2);
    // Only load (7), updown (5), en (4) and the clock select (1:0) exist in TCR.
    localparam logic [DATA_W-1:0] TCR_MASK = 8'b1011_0011;

    // The state names the bus phase completed on the previous cycle, so the
    // first access cycle is seen while the register still holds SETUP.
`ifdef TIMER_APB_WAIT_EN
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
`endif

    state_t state_reg;

    logic [DATA_W-1:0] tdr_reg;
    logic [DATA_W-1:0] tcr_reg;
    logic [1:0]        tsr_reg;
    logic [1:0]        flag_set;

    logic access_phase;
    logic sel_tdr;
    logic sel_tcr;
    logic sel_tsr;
    logic addr_err;
    logic wr_commit;

    assign access_phase = psel & penable;

    // pready is decoded from the registered phase plus the live strobes, so a
    // zero-wait transfer completes in its first access cycle.
`ifdef TIMER_APB_WAIT_EN
    assign pready = access_phase & (state_reg == WAIT);
`else
    assign pready = access_phase & (state_reg == SETUP);
`endif

    assign sel_tdr   = (paddr == ADDR_TDR);
    assign sel_tcr   = (paddr == ADDR_TCR);
    assign sel_tsr   = (paddr == ADDR_TSR);
    assign addr_err  = ~(sel_tdr | sel_tcr | sel_tsr);
    assign wr_commit = pready & pwrite;
    assign pslverr   = pready & addr_err;
    assign flag_set  = {udf_set, ovf_set};

    // APB phase tracking; psel+penable straight from IDLE is ignored.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (psel && !penable) state_reg <= SETUP;
                end
                SETUP: begin
                    if (!psel) begin
                        state_reg <= IDLE;
                    end else if (penable) begin
`ifdef TIMER_APB_WAIT_EN
                        state_reg <= WAIT;
`else
                        state_reg <= ACCESS;
`endif
                    end
                end
`ifdef TIMER_APB_WAIT_EN
                WAIT: begin
                    if (access_phase) state_reg <= ACCESS;
                    else              state_reg <= IDLE;
                end
`endif
                ACCESS: begin
                    if (psel && !penable) state_reg <= SETUP;
                    else                  state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // TDR and TCR capture write data on the commit edge; TCR keeps only its real bits.
    always_ff @(posedge pclk) begin
        if (rst) begin
            tdr_reg <= '0;
            tcr_reg <= '0;
        end else if (wr_commit) begin
            if (sel_tdr) tdr_reg <= pwdata;
            if (sel_tcr) tcr_reg <= pwdata & TCR_MASK;
        end
    end

    // Sticky flags: a counter pulse sets, a written 0 clears, set beats clear.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tsr
            always_ff @(posedge pclk) begin
                if (rst) begin
                    tsr_reg[gi] <= 1'b0;
                end else if (flag_set[gi]) begin
                    tsr_reg[gi] <= 1'b1;
                end else if (wr_commit && sel_tsr && !pwdata[gi]) begin
                    tsr_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Read mux: data only on a completing read, zero otherwise and for holes.
    always_comb begin
        prdata = '0;
        if (pready && !pwrite) begin
            if (sel_tdr)      prdata = tdr_reg;
            else if (sel_tcr) prdata = tcr_reg;
            else if (sel_tsr) prdata = {{(DATA_W-2){1'b0}}, tsr_reg};
        end
    end

    assign tdr_o    = tdr_reg;
    assign load_o   = tcr_reg[7];
    assign updown_o = tcr_reg[5];
    assign en_o     = tcr_reg[4];
    assign cks_o    = tcr_reg[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
// Scoreboard bench for timer_apb_regs: the driver pushes the expected read
// data / error response for each transfer, a negedge monitor pops and compares
// whenever pready is seen. A register-level model tracks TDR/TCR/TSR.
module tb_timer_apb_regs;

    logic       pclk = 1'b0;
    logic       rst;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       ovf_set;
    logic       udf_set;
    logic [7:0] tdr_o;
    logic       load_o;
    logic       updown_o;
    logic       en_o;
    logic [1:0] cks_o;

    timer_apb_regs #(.ADDR_W(8), .DATA_W(8)) dut (
        .pclk     (pclk),
        .rst      (rst),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .ovf_set  (ovf_set),
        .udf_set  (udf_set),
        .tdr_o    (tdr_o),
        .load_o   (load_o),
        .updown_o (updown_o),
        .en_o     (en_o),
        .cks_o    (cks_o)
    );

    always #5 pclk = ~pclk;

`ifdef TIMER_APB_WAIT_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       wr;
        logic [7:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model of the register contents
    logic [7:0] m_tdr;
    logic [7:0] m_tcr;
    logic [7:0] m_tsr;

    // Monitor: every completing transfer must match the oldest expectation;
    // between transfers the read bus and error line must be quiet.
    always @(negedge pclk) begin
        if (!rst) begin
            if (pready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pready: got prdata=%h pslverr=%b, required no transfer", prdata, pslverr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (prdata !== mon_e.data || pslverr !== mon_e.err) begin
                        bad++;
                        $display("FAIL xfer wr=%b addr=%h: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                                 mon_e.wr, mon_e.addr, prdata, pslverr, mon_e.data, mon_e.err);
                    end else begin
                        $display("xfer wr=%b addr=%h prdata=%h pslverr=%b ok", mon_e.wr, mon_e.addr, prdata, pslverr);
                    end
                end
            end else if (prdata !== 8'h00 || pslverr !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL idle_bus: got prdata=%h pslverr=%b, required 00 and 0", prdata, pslverr);
            end
        end
    end

    task automatic check_outs(input string tag);
        logic [12:0] got;
        logic [12:0] want;
        got  = {tdr_o, load_o, updown_o, en_o, cks_o};
        want = {m_tdr, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL outs_%s: got tdr=%h ld/ud/en/cks=%b, required tdr=%h ld/ud/en/cks=%b",
                     tag, got[12:5], got[4:0], want[12:5], want[4:0]);
        end
    endtask

    // One APB transfer; pulse is {udf,ovf} asserted on the completing edge.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] d,
                        input logic [1:0] pulse, input bit b2b);
        exp_t e;
        int   cyc;
        bit   got;
        e.wr   = wr;
        e.addr = addr;
        e.err  = !(addr inside {8'h00, 8'h01, 8'h02});
        e.data = 8'h00;
        if (!wr) begin
            case (addr)
                8'h00:   e.data = m_tdr;
                8'h01:   e.data = m_tcr;
                8'h02:   e.data = m_tsr;
                default: e.data = 8'h00;
            endcase
        end else begin
            case (addr)
                8'h00:   m_tdr = d;
                8'h01:   m_tcr = d & 8'hB3;
                8'h02:   m_tsr = m_tsr & d;
                default: ;
            endcase
        end
        m_tsr = m_tsr | {6'b0, pulse};
        exp_q.push_back(e);

        if (!b2b) begin
            @(posedge pclk); #1;
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        got = 0;
        while (!got && cyc <= 6) begin
            @(negedge pclk);
            if (pready) got = 1;
            else begin
                @(posedge pclk); #1;
                cyc++;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout addr=%h: got no pready in 6 cycles, required pready", addr);
            exp_q.delete(exp_q.size() - 1);
        end else if (cyc != EXP_LAT) begin
            bad++;
            $display("FAIL latency addr=%h: got pready after %0d cycles, required %0d", addr, cyc, EXP_LAT);
        end
        ovf_set = pulse[0];
        udf_set = pulse[1];
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;
        check_outs("after_xfer");
    endtask

    task automatic pulse_flags(input logic [1:0] p);
        @(posedge pclk); #1;
        ovf_set = p[0];
        udf_set = p[1];
        @(posedge pclk); #1;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        m_tsr = m_tsr | {6'b0, p};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [1:0] p;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; ovf_set = 1'b0; udf_set = 1'b0;
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 8'h00;
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge pclk);
        total++;
        if ({prdata, pready, pslverr, tdr_o, load_o, updown_o, en_o, cks_o} !== 23'd0) begin
            bad++;
            $display("FAIL reset_state: got prdata=%h pready=%b pslverr=%b tdr=%h ctl=%b%b%b%b, required all 0",
                     prdata, pready, pslverr, tdr_o, load_o, updown_o, en_o, cks_o);
        end

        xfer(0, 8'h00, 8'h00, 2'b00, 0);
        xfer(0, 8'h01, 8'h00, 2'b00, 0);
        xfer(0, 8'h02, 8'h00, 2'b00, 0);

        xfer(1, 8'h00, 8'hA5, 2'b00, 0);
        xfer(1, 8'h01, 8'hFF, 2'b00, 0);
        xfer(0, 8'h01, 8'h00, 2'b00, 0);

        // Sticky flag set/clear behaviour
        pulse_flags(2'b10);
        xfer(0, 8'h02, 8'h00, 2'b00, 0);
        xfer(1, 8'h02, 8'h00, 2'b00, 0);
        xfer(0, 8'h02, 8'h00, 2'b00, 0);
        xfer(1, 8'h02, 8'hFF, 2'b00, 0);
        xfer(0, 8'h02, 8'h00, 2'b00, 0);
        xfer(1, 8'h02, 8'h00, 2'b01, 0);
        xfer(0, 8'h02, 8'h00, 2'b00, 1);

        // Reset during the access cycle of a TCR write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h31;
        @(posedge pclk); #1;
        penable = 1'b1;
        rst = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 8'h00;
        total++;
        if ({prdata, pready, pslverr, tdr_o, load_o, updown_o, en_o, cks_o} !== 23'd0) begin
            bad++;
            $display("FAIL mid_reset: got prdata=%h pready=%b pslverr=%b tdr=%h ctl=%b%b%b%b, required all 0",
                     prdata, pready, pslverr, tdr_o, load_o, updown_o, en_o, cks_o);
        end
        xfer(0, 8'h01, 8'h00, 2'b00, 0);
        xfer(0, 8'h02, 8'h00, 2'b00, 0);

        // Unmapped address
        xfer(1, 8'h00, 8'h3C, 2'b00, 0);
        xfer(1, 8'h05, 8'h55, 2'b00, 0);
        xfer(0, 8'h05, 8'h00, 2'b00, 1);
        xfer(0, 8'h00, 8'h00, 2'b00, 0);

        // psel+penable without a setup phase must be ignored
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            total++;
            if (pready !== 1'b0) begin
                bad++;
                $display("FAIL protocol_violation: got pready=%b, required 0", pready);
            end
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        xfer(0, 8'h00, 8'h00, 2'b00, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            a = 8'($urandom_range(0, 9));
            if (a > 8'd8) a = 8'($urandom);
            else          a = a % 8'd3;
            p = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 7) == 0) pulse_flags(2'($urandom_range(1, 3)));
            xfer(1'($urandom_range(0, 1)), a, 8'($urandom), p, bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge pclk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d unanswered transfers, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
